// File: rtl/modulo_arbitro_buffer_rolhas_if.sv
// Request/status bundle between the cork-buffer arbiter and its
// requesters and display/MEF consumers.
interface modulo_arbitro_buffer_rolhas_if;
  logic       start_stop;
  logic       req_op;
  logic [6:0] op_qtd;
  logic       req_tr;
  logic       consume;
  logic [6:0] buf_sec;
  logic [4:0] buf_pri;
  logic       gnt_op;
  logic       gnt_tr;
  logic       done;
  logic       ovf_err;
  logic       sec_vazio;
  logic       pri_vazio;
  logic [1:0] estado;

  modport master (
    output start_stop,
    output req_op,
    output op_qtd,
    output req_tr,
    output consume,
    input  buf_sec,
    input  buf_pri,
    input  gnt_op,
    input  gnt_tr,
    input  done,
    input  ovf_err,
    input  sec_vazio,
    input  pri_vazio,
    input  estado
  );

  modport slave (
    input  start_stop,
    input  req_op,
    input  op_qtd,
    input  req_tr,
    input  consume,
    output buf_sec,
    output buf_pri,
    output gnt_op,
    output gnt_tr,
    output done,
    output ovf_err,
    output sec_vazio,
    output pri_vazio,
    output estado
  );
endinterface

// File: rtl/modulo_arbitro_buffer_rolhas.sv
// Cork-buffer arbiter: round-robin between operator loads and
// secondary-to-main transfers, owning both buffer counters.
module modulo_arbitro_buffer_rolhas #(
  parameter int SEC_MAX  = 99,
  parameter int PRI_MAX  = 31,
  parameter int TRANSFER = 20
) (
  input  logic clk,
  input  logic clr,
  modulo_arbitro_buffer_rolhas_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_CARGA  = 2'b01,
    S_TRANSF = 2'b10,
    S_FIM    = 2'b11
  } state_t;

  localparam logic [7:0] SEC_LIM = 8'(SEC_MAX);
  localparam logic [4:0] PRI_LIM = 5'(PRI_MAX);
  localparam logic [6:0] TR_LEN  = 7'(TRANSFER);

  state_t     r_state;
  state_t     w_state_nx;
  logic [6:0] r_buf_sec;
  logic [6:0] w_sec_nx;
  logic [4:0] r_buf_pri;
  logic [4:0] w_pri_nx;
  logic [6:0] r_qtd;
  logic [6:0] w_qtd_nx;
  logic [6:0] r_cnt;
  logic [6:0] w_cnt_nx;
  logic       r_rej;
  logic       w_rej_nx;
  logic       r_last;
  logic       w_last_nx;
  logic       r_pend_op;
  logic       w_pend_op_nx;
  logic       r_pend_tr;
  logic       w_pend_tr_nx;
  logic       r_req_op_d;
  logic       r_req_tr_d;

  logic       w_run;
  logic       w_edge_op;
  logic       w_edge_tr;
  logic       w_take_op;
  logic       w_take_tr;
  logic       w_move;
  logic       w_cons;
  logic [7:0] w_sum;
  logic       w_fit;

  assign w_run     = bus.start_stop;
  assign w_edge_op = bus.req_op & ~r_req_op_d;
  assign w_edge_tr = bus.req_tr & ~r_req_tr_d;
  assign w_sum     = {1'b0, r_buf_sec}
                   + {1'b0, bus.op_qtd};
  assign w_fit     = (w_sum <= SEC_LIM);

  assign w_move = w_run
                & (r_state == S_TRANSF)
                & (r_buf_sec != 7'd0)
                & (r_buf_pri != PRI_LIM);

  // A cork moved in and consumed the same cycle nets to zero on the main buffer
  assign w_cons = w_run & bus.consume
                & ((r_buf_pri != 5'd0) | w_move);

  // r_last=1 means transfer was served last; a tie goes to the other side
  always_comb begin
    w_take_op = 1'b0;
    w_take_tr = 1'b0;
    if (w_run && r_state == S_IDLE) begin
      unique case (1'b1)
        (r_pend_op && !r_pend_tr): w_take_op = 1'b1;
        (r_pend_tr && !r_pend_op): w_take_tr = 1'b1;
        (r_pend_op && r_pend_tr): begin
          w_take_op = r_last;
          w_take_tr = ~r_last;
        end
        default: w_take_op = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_pend_op_nx = 1'b0;
    w_pend_tr_nx = 1'b0;
    if (w_run) begin
      w_pend_op_nx = ~w_take_op
                   & (r_pend_op | w_edge_op);
      w_pend_tr_nx = ~w_take_tr
                   & (r_pend_tr | w_edge_tr);
    end
  end

  always_comb begin
    w_sec_nx = r_buf_sec;
    if (w_run && r_state == S_CARGA)
      w_sec_nx = r_buf_sec + 7'd1;
    if (w_move)
      w_sec_nx = r_buf_sec - 7'd1;
    unique case ({w_move, w_cons})
      2'b10:   w_pri_nx = r_buf_pri + 5'd1;
      2'b01:   w_pri_nx = r_buf_pri - 5'd1;
      default: w_pri_nx = r_buf_pri;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    w_qtd_nx   = r_qtd;
    w_cnt_nx   = r_cnt;
    w_rej_nx   = r_rej;
    w_last_nx  = r_last;
    if (!w_run) begin
      w_state_nx = S_IDLE;
      w_rej_nx   = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_take_op) begin
            w_qtd_nx  = bus.op_qtd;
            w_cnt_nx  = 7'd0;
            w_last_nx = 1'b0;
            if (!w_fit) begin
              w_state_nx = S_FIM;
              w_rej_nx   = 1'b1;
            end else if (bus.op_qtd == 7'd0) begin
              w_state_nx = S_FIM;
            end else begin
              w_state_nx = S_CARGA;
            end
          end else if (w_take_tr) begin
            w_cnt_nx   = 7'd0;
            w_last_nx  = 1'b1;
            w_state_nx = S_TRANSF;
          end
        end
        S_CARGA: begin
          w_cnt_nx = r_cnt + 7'd1;
          if (r_cnt + 7'd1 == r_qtd)
            w_state_nx = S_FIM;
        end
        S_TRANSF: begin
          if (!w_move) begin
            w_state_nx = S_FIM;
          end else begin
            w_cnt_nx = r_cnt + 7'd1;
            if (r_cnt + 7'd1 == TR_LEN
                || r_buf_sec == 7'd1
                || w_pri_nx == PRI_LIM)
              w_state_nx = S_FIM;
          end
        end
        S_FIM: begin
          w_state_nx = S_IDLE;
          w_rej_nx   = 1'b0;
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state    <= S_IDLE;
      r_buf_sec  <= 7'd0;
      r_buf_pri  <= 5'd0;
      r_qtd      <= 7'd0;
      r_cnt      <= 7'd0;
      r_rej      <= 1'b0;
      r_last     <= 1'b0;
      r_pend_op  <= 1'b0;
      r_pend_tr  <= 1'b0;
      r_req_op_d <= 1'b0;
      r_req_tr_d <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_buf_sec  <= w_sec_nx;
      r_buf_pri  <= w_pri_nx;
      r_qtd      <= w_qtd_nx;
      r_cnt      <= w_cnt_nx;
      r_rej      <= w_rej_nx;
      r_last     <= w_last_nx;
      r_pend_op  <= w_pend_op_nx;
      r_pend_tr  <= w_pend_tr_nx;
      r_req_op_d <= bus.req_op;
      r_req_tr_d <= bus.req_tr;
    end
  end

  assign bus.buf_sec   = r_buf_sec;
  assign bus.buf_pri   = r_buf_pri;
  assign bus.gnt_op    = (r_state == S_CARGA);
  assign bus.gnt_tr    = (r_state == S_TRANSF);
  assign bus.done      = (r_state == S_FIM);
  assign bus.ovf_err   = (r_state == S_FIM) & r_rej;
  assign bus.sec_vazio = (r_buf_sec == 7'd0);
  assign bus.pri_vazio = (r_buf_pri == 5'd0);
  assign bus.estado    = r_state;

endmodule

// File: tb/tb_modulo_arbitro_buffer_rolhas.sv
// Scoreboard bench: stimulus pushes predicted transaction results,
// the monitor pops one per done pulse and compares.
module tb_modulo_arbitro_buffer_rolhas;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  modulo_arbitro_buffer_rolhas_if bus();

  modulo_arbitro_buffer_rolhas dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  typedef struct {
    bit is_tr;
    bit rej;
    int sec;
    int pri;
    int len;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   m_sec;
  int   m_pri;
  bit   m_last_tr;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic exp_t m_op(int q);
    exp_t e;
    m_last_tr = 1'b0;
    e.is_tr = 1'b0;
    e.rej = (m_sec + q > 99);
    if (!e.rej) m_sec += q;
    e.len = e.rej ? 0 : q;
    e.sec = m_sec;
    e.pri = m_pri;
    return e;
  endfunction

  // cons: consume on every other TRANSF cycle starting with the first
  function automatic exp_t m_tr(bit cons);
    exp_t e;
    int k;
    int cyc;
    bit go;
    m_last_tr = 1'b1;
    e.is_tr = 1'b1;
    e.rej = 1'b0;
    if (!cons) begin
      k = 20;
      if (m_sec < k) k = m_sec;
      if (31 - m_pri < k) k = 31 - m_pri;
      m_sec -= k;
      m_pri += k;
      e.len = (k > 0) ? k : 1;
    end else begin
      k = 0;
      cyc = 0;
      go = 1'b1;
      while (go) begin
        bit c;
        bit mv;
        c = (cyc % 2 == 0);
        mv = (m_sec > 0) && (m_pri < 31);
        if (mv) begin
          m_sec--;
          k++;
          if (!c) m_pri++;
        end else if (c && m_pri > 0) begin
          m_pri--;
        end
        cyc++;
        go = mv && k < 20 && m_sec > 0 && m_pri < 31;
      end
      e.len = cyc;
    end
    e.sec = m_sec;
    e.pri = m_pri;
    return e;
  endfunction

  int   glen;
  bit   gsaw_tr;
  exp_t me;

  always @(negedge clk) begin
    if (clr) begin
      if (bus.gnt_op || bus.gnt_tr) glen++;
      if (bus.gnt_tr) gsaw_tr = 1'b1;
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          me = sb.pop_front();
          chk("kind_tr", int'(gsaw_tr), int'(me.is_tr));
          chk("ovf_err", int'(bus.ovf_err), int'(me.rej));
          chk("buf_sec", int'(bus.buf_sec), me.sec);
          chk("buf_pri", int'(bus.buf_pri), me.pri);
          chk("gnt_len", glen, me.len);
          chk("sec_vazio", int'(bus.sec_vazio),
              int'(me.sec == 0));
          chk("pri_vazio", int'(bus.pri_vazio),
              int'(me.pri == 0));
        end
      end
      if (bus.estado == 2'b00) begin
        glen = 0;
        gsaw_tr = 1'b0;
      end
    end else begin
      glen = 0;
      gsaw_tr = 1'b0;
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(sb.size() == 0 && bus.estado == 2'b00)
           && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      chk("timeout_idle", 1, 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_gnt(bit tr);
    int n;
    n = 0;
    while (!(tr ? bus.gnt_tr : bus.gnt_op) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("timeout_gnt", 1, 0);
  endtask

  task automatic pulse(bit op, bit tr);
    @(negedge clk);
    if (op) bus.req_op = 1'b1;
    if (tr) bus.req_tr = 1'b1;
    @(negedge clk);
    bus.req_op = 1'b0;
    bus.req_tr = 1'b0;
  endtask

  task automatic run_op(int q);
    bus.op_qtd = 7'(q);
    sb.push_back(m_op(q));
    pulse(1'b1, 1'b0);
    wait_idle();
  endtask

  task automatic run_tr();
    sb.push_back(m_tr(1'b0));
    pulse(1'b0, 1'b1);
    wait_idle();
  endtask

  task automatic run_tr_cons();
    int i;
    sb.push_back(m_tr(1'b1));
    pulse(1'b0, 1'b1);
    wait_gnt(1'b1);
    i = 0;
    while (bus.gnt_tr && i < 60) begin
      bus.consume = (i % 2 == 0);
      i++;
      @(negedge clk);
    end
    bus.consume = 1'b0;
    wait_idle();
  endtask

  task automatic run_tie(int q);
    bus.op_qtd = 7'(q);
    if (m_last_tr) begin
      sb.push_back(m_op(q));
      sb.push_back(m_tr(1'b0));
    end else begin
      sb.push_back(m_tr(1'b0));
      sb.push_back(m_op(q));
    end
    pulse(1'b1, 1'b1);
    wait_idle();
  endtask

  task automatic burst(int n);
    for (int i = 0; i < n; i++) begin
      bus.consume = 1'b1;
      if (m_pri > 0) m_pri--;
      @(negedge clk);
    end
    bus.consume = 1'b0;
    @(negedge clk);
    chk("burst_pri", int'(bus.buf_pri), m_pri);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b0;
    sb.delete();
    m_sec = 0;
    m_pri = 0;
    m_last_tr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_estado"}, int'(bus.estado), 0);
    chk({tag, "_sec"}, int'(bus.buf_sec), 0);
    chk({tag, "_pri"}, int'(bus.buf_pri), 0);
    chk({tag, "_gnt_op"}, int'(bus.gnt_op), 0);
    chk({tag, "_gnt_tr"}, int'(bus.gnt_tr), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_ovf"}, int'(bus.ovf_err), 0);
    chk({tag, "_sec_vazio"}, int'(bus.sec_vazio), 1);
    chk({tag, "_pri_vazio"}, int'(bus.pri_vazio), 1);
  endtask

  initial begin
    int base;
    int q;
    clr = 1'b0;
    bus.start_stop = 1'b0;
    bus.req_op = 1'b0;
    bus.req_tr = 1'b0;
    bus.op_qtd = 7'd0;
    bus.consume = 1'b0;
    m_sec = 0;
    m_pri = 0;
    m_last_tr = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst");
    clr = 1'b1;
    bus.start_stop = 1'b1;
    @(negedge clk);

    run_op(40);
    run_tr();
    run_op(70);
    run_op(10);
    run_op(9);
    run_op(0);
    run_op(127);

    do_reset();
    run_op(28);
    run_tr();
    run_tr();
    run_op(5);
    run_tr_cons();
    run_tr();

    do_reset();
    run_tie(30);
    run_tie(10);

    bus.op_qtd = 7'd5;
    sb.push_back(m_tr(1'b0));
    sb.push_back(m_op(5));
    pulse(1'b0, 1'b1);
    wait_gnt(1'b1);
    bus.req_op = 1'b1;
    @(negedge clk);
    bus.req_op = 1'b0;
    wait_idle();

    // start_stop drop after seven loaded corks
    base = m_sec;
    bus.op_qtd = 7'd20;
    pulse(1'b1, 1'b0);
    wait_gnt(1'b0);
    for (int j = 0; j < 7; j++) begin
      if (j == 2) bus.req_tr = 1'b1;
      if (j == 3) bus.req_tr = 1'b0;
      @(negedge clk);
    end
    bus.start_stop = 1'b0;
    @(negedge clk);
    m_sec = base + 7;
    m_last_tr = 1'b0;
    chk("stop_estado", int'(bus.estado), 0);
    chk("stop_sec", int'(bus.buf_sec), m_sec);
    bus.start_stop = 1'b1;
    repeat (6) @(negedge clk);
    chk("stop_pend_clr", int'(bus.estado), 0);
    chk("stop_sec_hold", int'(bus.buf_sec), m_sec);

    burst(10);
    if (m_sec < 5) run_op(10);
    sb.push_back(m_tr(1'b0));
    pulse(1'b0, 1'b1);
    wait_gnt(1'b1);
    @(negedge clk);
    #2;
    clr = 1'b0;
    sb.delete();
    #1;
    chk_reset_vals("clr_mid");
    m_sec = 0;
    m_pri = 0;
    m_last_tr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);

    for (int it = 0; it < 40; it++) begin
      q = ($urandom_range(0, 3) == 0)
        ? int'($urandom_range(0, 127))
        : int'($urandom_range(0, 40));
      case ($urandom_range(0, 3))
        0: run_op(q);
        1: run_tr();
        2: run_tie(q);
        default: burst(int'($urandom_range(1, 15)));
      endcase
    end

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/modulo_arbitro_buffer_rolhas.md
# modulo_arbitro_buffer_rolhas

Cork-buffer arbiter and sequencer for the bottle-sealing line. It owns the secondary cork buffer (0–99) and the main cork buffer (0–31) and shares the secondary buffer between two requesters: operator loads (add N corks) and automatic transfers to the main buffer (move a fixed batch). Both requesters go through one explicit arbitration point with round-robin fairness, so the two operations can never collide. The block sits between the operator/transfer request logic and the 7-segment/MEF consumers, which read its buffer outputs.

## Interface
- SEC_MAX, 99, secondary buffer capacity
- PRI_MAX, 31, main buffer capacity (5-bit)
- TRANSFER, 20, corks moved per transfer grant
- clk  in  1  system clock (divided clock domain)
- clr  in  1  asynchronous, active-low reset
- start_stop  in  1  system enable; 0 aborts and blocks all activity
- req_op  in  1  operator load request (level, rising-edge captured)
- op_qtd  in  7  corks to load; sampled at grant
- req_tr  in  1  transfer request (level, rising-edge captured)
- consume  in  1  one cork consumed from main buffer this cycle (sealing)
- buf_sec  out  7  secondary buffer count
- buf_pri  out  5  main buffer count
- gnt_op  out  1  high while in CARGA
- gnt_tr  out  1  high while in TRANSF
- done  out  1  one-cycle pulse in FIM
- ovf_err  out  1  one-cycle pulse in FIM when a load was rejected
- sec_vazio  out  1  buf_sec == 0
- pri_vazio  out  1  buf_pri == 0 (feeds MEF `ro`)
- estado  out  2  IDLE=00, CARGA=01, TRANSF=10, FIM=11

## Operation
- Edge capture: registered req_x_d. A rising edge (req_x=1, req_x_d=0) sets pend_x. pend_x clears on the cycle its grant is taken. Repeated edges while pending are absorbed.
- Arbitration happens in IDLE only, when start_stop=1.
  - One pending: grant it.
  - Both pending: grant the one not served last. The `last` register resets to op, so transfer wins the first tie.
- Grant to op:
  - Latch qtd=op_qtd and cnt=0.
  - If buf_sec+op_qtd > SEC_MAX (8-bit compare) → FIM with rej=1, no change.
  - If op_qtd==0 → FIM.
  - Otherwise → CARGA.
- CARGA: each edge buf_sec+=1 and cnt+=1. When cnt+1==qtd → FIM.
- Grant to tr: cnt=0 → TRANSF.
- TRANSF: each edge moves one cork (buf_sec-=1, buf_pri+=1) while buf_sec>0 and buf_pri<PRI_MAX. Exit to FIM when any of these holds after the move:
  - cnt+1==TRANSFER
  - buf_sec becomes 0
  - buf_pri reaches PRI_MAX
  - Entered with buf_sec==0 or buf_pri==PRI_MAX: zero moves, → FIM next edge.
- FIM: done=1, ovf_err=rej. Next edge → IDLE, rej=0.
- consume, in any state while start_stop=1:
  - buf_pri-=1 if buf_pri>0.
  - At 0 it is ignored; no wrap.
  - In TRANSF a move and a consume in the same cycle give net buf_pri unchanged, buf_sec-=1, and the full-check uses the net value.
- start_stop=0:
  - Synchronous → IDLE; pend_op and pend_tr cleared.
  - Corks already moved or loaded stay.
  - consume ignored; buffers hold.
- No arithmetic wraps. buf_sec stays in [0,SEC_MAX] and buf_pri in [0,PRI_MAX] by construction.

## Timing
- Reset (clr=0, async):
  - State: estado=IDLE, buf_sec=0, buf_pri=0, pend_op=pend_tr=0, last=op.
  - Outputs: gnt_op=gnt_tr=done=ovf_err=0, sec_vazio=1, pri_vazio=1.
- Reset mid-operation returns everything to the reset values immediately.
- Request latency: req rises in cycle 0 → pend=1 in cycle 1 → grant state in cycle 2 → first count change visible in cycle 3.
- Load of N (accepted): CARGA lasts N cycles and buf_sec reaches final value entering FIM. Grant-to-done is N+1 cycles.
- Transfer of k corks: TRANSF lasts max(k,1) cycles, then 1 FIM cycle.
- gnt_*, done, ovf_err and estado are Moore outputs decoded from registered state. sec_vazio and pri_vazio decode the registered counts.
- A request edge arriving during any non-IDLE state is captured and served after FIM.

## Test plan
- Reset, start_stop=1, op_qtd=40, pulse req_op → CARGA 40 cycles, buf_sec=40, done pulses once, ovf_err=0.
- buf_sec=40, pulse req_tr → 20 moves: buf_sec=20, buf_pri=20, TRANSF 20 cycles, gnt_tr high throughout.
- buf_sec=90, op_qtd=10 → FIM with ovf_err=1, buf_sec stays 90. Then op_qtd=9 → buf_sec=99.
- buf_sec=5, buf_pri=28, req_tr with consume=1 every other cycle → transfer stops at buf_sec=0 or buf_pri=31. Counts sum is conserved minus consumed corks; never exceeds 31.
- req_op and req_tr rise in the same cycle after reset → tr served first, then op. Repeat the tie → tr served first again (alternation after op). Raise req_op mid-TRANSF → served after FIM.
- start_stop drops mid-CARGA at cnt=7 → IDLE next edge, buf_sec=+7, pending requests cleared. clr low mid-TRANSF → all reset values asynchronously.
